fb_scanout: RTL

FB_SCANOUT -- requirements
Module: fb_scanout

---
 rtl/gpu_pkg.sv | 34 +++
 rtl/scanout_line_buffer.sv | 22 ++
 rtl/fb_scanout.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/gpu_pkg.sv
// Shared scanout types: fetch FSM states, pixel format codes and 16-bit to
// 24-bit colour expansion.
package gpu_pkg;

  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,
    FS_ISSUE = 2'd1,
    FS_WAIT  = 2'd2
  } fetch_state_t;

  localparam logic FMT_RGB555 = 1'b0;
  localparam logic FMT_RGB565 = 1'b1;

  // Low bits are filled with the field's top bits so full-scale maps to 8'hFF.
  function automatic logic [23:0] expand_rgb(input logic fmt, input logic [15:0] w);
    logic [4:0]  r5;
    logic [4:0]  g5;
    logic [5:0]  g6;
    logic [4:0]  b5;
    logic [23:0] rgb;
    r5 = w[15:11];
    if (fmt == FMT_RGB565) begin
      g6  = w[10:5];
      b5  = w[4:0];
      rgb = {r5, r5[4:2], g6, g6[5:4], b5, b5[4:2]};
    end else begin
      g5  = w[10:6];
      b5  = w[5:1];
      rgb = {r5, r5[4:2], g5, g5[4:2], b5, b5[4:2]};
    end
    return rgb;
  endfunction

endpackage

// File: rtl/scanout_line_buffer.sv
// Ping-pong line storage: one write port for the fetcher, one registered
// read port for the display, both on the pixel clock.
module scanout_line_buffer #(
  parameter int DEPTH = 800,
  parameter int AW    = 10
) (
  input  logic          pixclk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [15:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [15:0]   rdata
);

  logic [15:0] mem [DEPTH];

  always_ff @(posedge pixclk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/fb_scanout.sv
// Framebuffer scanout: upscales a SRC_W x SRC_H image from memory to the
// display, prefetching one source row ahead into a ping-pong line buffer.
module fb_scanout
  import gpu_pkg::*;
#(
  parameter int                SRC_W      = 400,
  parameter int                SRC_H      = 240,
  parameter int                SCALE_LOG2 = 1,
  parameter int                DISP_H     = 480,
  parameter int                ADDR_W     = 19,
  parameter logic [ADDR_W-1:0] FB_BASE    = '0,
  parameter logic [23:0]       BORDER     = 24'h000000
) (
  input  logic              pixclk,
  input  logic              reset,
  input  logic              fmt,
  input  logic [10:0]       nextX,
  input  logic [10:0]       nextY,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [15:0]       mem_rdata,
  output logic [7:0]        red,
  output logic [7:0]        green,
  output logic [7:0]        blue,
  output logic              busy,
  output logic              underrun
);

  localparam int                LB_AW    = $clog2(2 * SRC_W);
  localparam int                COL_W    = $clog2(SRC_W + 1);
  localparam logic [11:0]       SRC_W_L  = 12'(SRC_W);
  localparam logic [11:0]       SRC_H_L  = 12'(SRC_H);
  localparam logic [11:0]       SWAP_LIM = 12'(SRC_H << SCALE_LOG2);
  localparam logic [10:0]       DISP_H_L = 11'(DISP_H);
  localparam logic [10:0]       SUB_MASK = 11'((1 << SCALE_LOG2) - 1);
  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(SRC_W - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(SRC_W);
  localparam logic [LB_AW-1:0]  BUF1_OFS = LB_AW'(SRC_W);

  fetch_state_t      state;
  logic [COL_W-1:0]  col;
  logic [ADDR_W-1:0] row_base;
  logic [ADDR_W-1:0] next_base;
  logic              disp_buf;
  logic              fill_buf;
  logic              wr_buf;
  logic [10:0]       sx;
  logic [10:0]       sy;
  logic              in_image;
  logic              row0_trig;
  logic              swap;
  logic              more_rows;
  logic              rd_buf;
  logic [LB_AW-1:0]  raddr;
  logic [LB_AW-1:0]  waddr;
  logic              lb_we;
  logic [15:0]       lb_rdata;
  logic              vld_p1;
  logic              border_p1;
  logic              fmt_p1;

  assign sx        = nextX >> SCALE_LOG2;
  assign sy        = nextY >> SCALE_LOG2;
  assign in_image  = ({1'b0, sx} < SRC_W_L) && ({1'b0, sy} < SRC_H_L);
  assign row0_trig = (nextX == 11'd0) && (nextY == DISP_H_L);
  assign swap      = (nextX == 11'd0) && ({1'b0, nextY} < SWAP_LIM) &&
                     ((nextY & SUB_MASK) == 11'd0);
  assign more_rows = ({1'b0, sy} + 12'd1) < SRC_H_L;
  assign next_base = row_base + ROW_STEP;
  assign busy      = (state != FS_IDLE);

  // The first pixel of a new source row must already come from the new buffer.
  assign rd_buf = swap ? fill_buf : disp_buf;
  assign raddr  = !in_image ? '0 : (rd_buf ? BUF1_OFS : '0) + LB_AW'(sx);
  assign lb_we  = (state == FS_WAIT) && mem_rvalid;
  assign waddr  = (wr_buf ? BUF1_OFS : '0) + LB_AW'(col);

  scanout_line_buffer #(
    .DEPTH (2 * SRC_W),
    .AW    (LB_AW)
  ) u_line_buffer (
    .pixclk (pixclk),
    .we     (lb_we),
    .waddr  (waddr),
    .wdata  (mem_rdata),
    .raddr  (raddr),
    .rdata  (lb_rdata)
  );

  always_ff @(posedge pixclk or posedge reset) begin
    if (reset) begin
      state    <= FS_IDLE;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      col      <= '0;
      row_base <= '0;
      disp_buf <= 1'b1;
      fill_buf <= 1'b0;
      wr_buf   <= 1'b0;
      underrun <= 1'b0;
    end else begin
      // A trigger arriving while a fetch runs is dropped; that fetch finishes
      // into the buffer it started on because wr_buf and mem_addr are its own.
      if (row0_trig) begin
        row_base <= '0;
        if (busy) begin
          underrun <= 1'b1;
        end else begin
          disp_buf <= 1'b1;
          fill_buf <= 1'b0;
          wr_buf   <= 1'b0;
          mem_addr <= FB_BASE;
          col      <= '0;
          mem_req  <= 1'b1;
          state    <= FS_ISSUE;
        end
      end else if (swap) begin
        disp_buf <= fill_buf;
        fill_buf <= disp_buf;
        if (more_rows) row_base <= next_base;
        if (busy) begin
          underrun <= 1'b1;
        end else if (more_rows) begin
          wr_buf   <= disp_buf;
          mem_addr <= FB_BASE + next_base;
          col      <= '0;
          mem_req  <= 1'b1;
          state    <= FS_ISSUE;
        end
      end

      case (state)
        FS_ISSUE: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            state   <= FS_WAIT;
          end
        end
        FS_WAIT: begin
          if (mem_rvalid) begin
            col      <= col + COL_W'(1);
            mem_addr <= mem_addr + ADDR_W'(1);
            if (col == COL_LAST) begin
              state <= FS_IDLE;
            end else begin
              mem_req <= 1'b1;
              state   <= FS_ISSUE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Stage p1: line-buffer read data, border flag and format arrive together
  always_ff @(posedge pixclk or posedge reset) begin
    if (reset) vld_p1 <= 1'b0;
    else       vld_p1 <= 1'b1;
  end

  always_ff @(posedge pixclk) begin
    border_p1 <= !in_image;
    fmt_p1    <= fmt;
  end

  assign {red, green, blue} = !vld_p1   ? 24'h000000 :
                              border_p1 ? BORDER     :
                                          expand_rgb(fmt_p1, lb_rdata);

endmodule
